ex_div_ctrl: RTL and testbench

Sequencing controller between the EX stage and the iterative divider (34-cycle `div_op`/`done` unit, result `{remainder, quotient}`). It accepts one DIV/DIVU request at a time and stalls the pipeline while the divider runs. It returns HI/LO as a one-cycle response and handles pipeline flushes without corrupting the divider. A watchdog recovers if the divider never completes.

---
 rtl/ex_div_ctrl.sv | 139 +++++++++++++
 tb/tb_ex_div_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_ctrl.sv
// Sequencing controller between the EX stage and a multi-cycle iterative divider.
// Holds the pipeline while a divide runs and returns HI/LO as a one-cycle response.
module ex_div_ctrl #(
  parameter int MAX_WAIT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divisor,
  input  logic        flush,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_hi,
  output logic [31:0] resp_lo,
  output logic        resp_div0,
  output logic        err,
  output logic [1:0]  div_op,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_done,
  input  logic [63:0] div_result
);

  localparam logic [5:0] WD_LIMIT = 6'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] dividend_reg, divisor_reg;
  logic [31:0] hi_reg, lo_reg;
  logic        signed_reg;
  logic        div0_reg;
  logic [5:0]  wd_cnt_reg;
  logic        accept;
  logic        capture;
  logic        wd_fire;
  logic        busy_state;

  assign busy_state = (state_reg == S_WAIT) || (state_reg == S_DRAIN);

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    resp_valid = 1'b0;
    err        = 1'b0;
    div_op     = 2'b00;
    accept     = 1'b0;
    capture    = 1'b0;
    // The divider cannot be aborted, so a missing done is the only way out of WAIT/DRAIN.
    wd_fire    = busy_state && !div_done && (wd_cnt_reg == WD_LIMIT);

    case (state_reg)
      S_IDLE: begin
        if (req_valid && !flush) begin
          accept     = 1'b1;
          stall      = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // div_done is still high from the previous idle period and is ignored here.
        stall      = 1'b1;
        div_op     = signed_reg ? 2'b10 : 2'b01;
        state_next = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (wd_fire) begin
          err        = 1'b1;
          state_next = S_IDLE;
        end else if (div_done) begin
          capture    = 1'b1;
          state_next = S_DONE;
        end else if (flush) begin
          state_next = S_DRAIN;
        end
      end
      S_DONE: begin
        resp_valid = !flush;
        state_next = S_IDLE;
      end
      S_DRAIN: begin
        stall = req_valid;
        if (wd_fire) begin
          err        = 1'b1;
          state_next = S_IDLE;
        end else if (div_done) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      dividend_reg <= 32'd0;
      divisor_reg  <= 32'd0;
      signed_reg   <= 1'b0;
      div0_reg     <= 1'b0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      wd_cnt_reg   <= 6'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        dividend_reg <= req_dividend;
        divisor_reg  <= req_divisor;
        signed_reg   <= req_signed;
        div0_reg     <= (req_divisor == 32'd0);
        wd_cnt_reg   <= 6'd0;
      end else if (busy_state) begin
        wd_cnt_reg <= wd_cnt_reg + 6'd1;
      end
      if (capture) begin
        hi_reg <= div_result[63:32];
        lo_reg <= div_result[31:0];
      end
    end
  end

  assign resp_hi      = hi_reg;
  assign resp_lo      = lo_reg;
  assign resp_div0    = div0_reg;
  assign div_dividend = dividend_reg;
  assign div_divisor  = divisor_reg;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed bench for ex_div_ctrl with a 34-cycle behavioural divider model.
// Table-driven divides plus hand sequences for flush, watchdog and mid-run reset.
module tb_ex_div_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_signed;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_hi;
  logic [31:0] resp_lo;
  logic        resp_div0;
  logic        err;
  logic [1:0]  div_op;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_done;
  logic [63:0] div_result;

  int n_vec  = 0;
  int n_fail = 0;

  ex_div_ctrl #(.MAX_WAIT(40)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_signed   (req_signed),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .flush        (flush),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .resp_hi      (resp_hi),
    .resp_lo      (resp_lo),
    .resp_div0    (resp_div0),
    .err          (err),
    .div_op       (div_op),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_done     (div_done),
    .div_result   (div_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: latches on div_op, done rises 34 edges later; hang keeps done low.
  logic        hang;
  logic [31:0] m_a, m_b;
  logic        m_signed;
  int          busy_cnt;

  function automatic logic [63:0] calc(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] sa, sb, sq, sr;
    logic [31:0] uq, ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = a; sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      div_done   <= 1'b1;
      div_result <= 64'd0;
      busy_cnt   <= 0;
    end else if (div_op != 2'b00) begin
      div_done <= 1'b0;
      busy_cnt <= hang ? 0 : 34;
      m_a      <= div_dividend;
      m_b      <= div_divisor;
      m_signed <= (div_op == 2'b10);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        div_done   <= 1'b1;
        div_result <= calc(m_a, m_b, m_signed);
      end
    end
  end

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          flush_k;
    logic        exp_valid;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_div0;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered just after a posedge with the DUT in IDLE; returns just after the edge ending DONE.
  task automatic do_div(input vec_t v, input string tag);
    req_valid    = 1'b1;
    req_signed   = v.sgn;
    req_dividend = v.a;
    req_divisor  = v.b;
    flush        = 1'b0;
    @(negedge clk);
    chk({tag, " idle stall"}, 64'(stall), 64'(1'b1));
    chk({tag, " idle resp_valid"}, 64'(resp_valid), 64'(1'b0));
    @(posedge clk); #1;
    for (int k = 0; k <= 36; k++) begin
      flush = (k == v.flush_k);
      @(negedge clk);
      chk($sformatf("%s c%0d stall", tag, k), 64'(stall), 64'(k <= 35));
      chk($sformatf("%s c%0d div_op", tag, k), 64'(div_op),
          64'((k == 0) ? (v.sgn ? 2'b10 : 2'b01) : 2'b00));
      chk($sformatf("%s c%0d resp_valid", tag, k), 64'(resp_valid),
          64'((k == 36) ? v.exp_valid : 1'b0));
      if (k == 0) begin
        chk({tag, " div_dividend"}, 64'(div_dividend), 64'(v.a));
        chk({tag, " div_divisor"}, 64'(div_divisor), 64'(v.b));
      end
      if (k == 36) begin
        chk({tag, " resp_lo"}, 64'(resp_lo), 64'(v.exp_lo));
        chk({tag, " resp_hi"}, 64'(resp_hi), 64'(v.exp_hi));
        chk({tag, " resp_div0"}, 64'(resp_div0), 64'(v.exp_div0));
      end
      @(posedge clk); #1;
    end
    flush     = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " stall"}, 64'(stall), 64'(1'b0));
    chk({tag, " resp_valid"}, 64'(resp_valid), 64'(1'b0));
    chk({tag, " err"}, 64'(err), 64'(1'b0));
    chk({tag, " div_op"}, 64'(div_op), 64'(2'b00));
    chk({tag, " resp_hi"}, 64'(resp_hi), 64'(32'd0));
    chk({tag, " resp_lo"}, 64'(resp_lo), 64'(32'd0));
    chk({tag, " resp_div0"}, 64'(resp_div0), 64'(1'b0));
    chk({tag, " div_dividend"}, 64'(div_dividend), 64'(32'd0));
    chk({tag, " div_divisor"}, 64'(div_divisor), 64'(32'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    //         sgn   dividend       divisor        flush_k valid  lo             hi             div0
    vecs[0] = '{1'b0, 32'd100,       32'd7,         -1,     1'b1,  32'd14,        32'd2,         1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         -1,     1'b1,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{1'b0, 32'd5,         32'd0,         -1,     1'b1,  32'hFFFF_FFFF, 32'd5,         1'b1};
    vecs[3] = '{1'b0, 32'd8,         32'd2,         -1,     1'b1,  32'd4,         32'd0,         1'b0};
    vecs[4] = '{1'b1, 32'd100,       32'hFFFF_FFF9, -1,     1'b1,  32'hFFFF_FFF2, 32'd2,         1'b0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h10,        -1,     1'b1,  32'h0FFF_FFFF, 32'hF,         1'b0};
    vecs[6] = '{1'b1, 32'h8000_0000, 32'd1,         -1,     1'b1,  32'h8000_0000, 32'd0,         1'b0};
    vecs[7] = '{1'b0, 32'd77,        32'd7,         35,     1'b1,  32'd11,        32'd0,         1'b0};
    vecs[8] = '{1'b0, 32'd77,        32'd7,         36,     1'b0,  32'd11,        32'd0,         1'b0};

    rst = 1'b0; hang = 1'b0;
    req_valid = 1'b0; req_signed = 1'b0; req_dividend = 32'd0; req_divisor = 32'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: each request is presented in the cycle right after the previous DONE.
    for (int i = 0; i < 9; i++) do_div(vecs[i], $sformatf("vec%0d", i));
    @(negedge clk);
    chk("hold resp_lo", 64'(resp_lo), 64'(32'd11));
    @(posedge clk); #1;

    // Flush in WAIT, then a new request waits in DRAIN until the divider finishes.
    req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd50; req_divisor = 32'd5;
    @(negedge clk);
    chk("flushw idle stall", 64'(stall), 64'(1'b1));
    @(posedge clk); #1;
    for (int k = 0; k <= 35; k++) begin
      if (k == 10) begin
        flush = 1'b1; req_valid = 1'b0;
      end else if (k == 11) begin
        flush = 1'b0; req_valid = 1'b1; req_dividend = 32'd9; req_divisor = 32'd3;
      end
      @(negedge clk);
      chk($sformatf("flushw c%0d stall", k), 64'(stall), 64'(1'b1));
      chk($sformatf("flushw c%0d resp_valid", k), 64'(resp_valid), 64'(1'b0));
      chk($sformatf("flushw c%0d div_op", k), 64'(div_op), 64'((k == 0) ? 2'b01 : 2'b00));
      @(posedge clk); #1;
    end
    v = '{1'b0, 32'd9, 32'd3, -1, 1'b1, 32'd3, 32'd0, 1'b0};
    do_div(v, "after_drain");

    // Watchdog: divider never completes.
    hang = 1'b1;
    req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd12; req_divisor = 32'd3;
    @(negedge clk);
    chk("wd idle stall", 64'(stall), 64'(1'b1));
    @(posedge clk); #1;
    for (int k = 0; k <= 41; k++) begin
      @(negedge clk);
      chk($sformatf("wd c%0d err", k), 64'(err), 64'(k == 41));
      chk($sformatf("wd c%0d resp_valid", k), 64'(resp_valid), 64'(1'b0));
      chk($sformatf("wd c%0d stall", k), 64'(stall), 64'(1'b1));
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    hang = 1'b0;
    for (int k = 42; k <= 43; k++) begin
      @(negedge clk);
      chk($sformatf("wd c%0d err", k), 64'(err), 64'(1'b0));
      chk($sformatf("wd c%0d stall", k), 64'(stall), 64'(1'b0));
      chk($sformatf("wd c%0d resp_valid", k), 64'(resp_valid), 64'(1'b0));
      @(posedge clk); #1;
    end

    // Reset in the middle of a divide, then a fresh request.
    req_valid = 1'b1; req_signed = 1'b0; req_dividend = 32'd20; req_divisor = 32'd4;
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst = 1'b1;
    @(posedge clk); #1;
    v = '{1'b0, 32'd20, 32'd4, -1, 1'b1, 32'd5, 32'd0, 1'b0};
    do_div(v, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
